// File: rtl/axi_stream_remove_header.sv
// AXI-Stream header stripper: drops R leading bytes per packet, repacks MSB-aligned.
// Define AXIS_RM_HDR_ERR_EN to add the err_short flag for dropped/malformed packets.
module axi_stream_remove_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
`ifdef AXIS_RM_HDR_ERR_EN
  output logic                    err_short,
`endif
  input  logic                    valid_remove,
  input  logic [BYTE_CNT_WD-1:0]  byte_remove_cnt,
  output logic                    ready_remove
);
  localparam int W   = DATA_BYTE_WD;
  localparam int CW  = $clog2(W + 1);
  localparam int SHW = $clog2(DATA_WD) + 1;
  localparam logic [CW:0] W_C = (CW+1)'(W);

  typedef enum logic [2:0] {
    IDLE, FIRST, STREAM, FLUSH, DRAIN
  } state_t;

  function automatic logic [W-1:0] msb_mask(input logic [CW:0] n);
    logic [W-1:0] m;
    m = '0;
    for (int i = 0; i < W; i++)
      m[W-1-i] = n > (CW+1)'(i);
    return m;
  endfunction

  function automatic logic [CW-1:0] popcnt(input logic [W-1:0] v);
    logic [CW-1:0] s;
    s = '0;
    for (int i = 0; i < W; i++)
      s = s + CW'(v[i]);
    return s;
  endfunction

  function automatic logic [DATA_WD-1:0] byte_mask(input logic [W-1:0] kp);
    logic [DATA_WD-1:0] m;
    for (int i = 0; i < W; i++)
      m[i*8 +: 8] = {8{kp[i]}};
    return m;
  endfunction

  state_t                 state, state_d;
  logic [BYTE_CNT_WD-1:0] r, r_d;
  logic [DATA_WD-1:0]     hold, hold_d;
  logic [DATA_WD-1:0]     beat_m, ld_data;
  logic [CW-1:0]          k, fcnt, fcnt_d;
  logic [CW:0]            kk, rr, c;
  logic [SHW-1:0]         sh_r, sh_wr;
  logic [W-1:0]           ld_keep;
  logic                   ld, ld_last, out_free;

  // hold keeps its valid bytes at the MSB end, lanes below zeroed
  assign beat_m   = data_in & byte_mask(keep_in);
  assign k        = popcnt(keep_in);
  assign kk       = {1'b0, k};
  assign rr       = (CW+1)'(r);
  assign c        = W_C - rr + kk;
  assign sh_r     = SHW'({r, 3'b000});
  assign sh_wr    = SHW'(DATA_WD) - sh_r;
  assign out_free = !valid_out | ready_out;

  always_comb begin
    state_d      = state;
    r_d          = r;
    hold_d       = hold;
    fcnt_d       = fcnt;
    ld           = 1'b0;
    ld_data      = '0;
    ld_keep      = '0;
    ld_last      = 1'b0;
    ready_in     = 1'b0;
    ready_remove = 1'b0;
    unique case (state)
      IDLE: begin
        ready_remove = 1'b1;
        if (valid_remove) begin
          r_d     = byte_remove_cnt;
          state_d = FIRST;
        end
      end
      FIRST: begin
        ready_in = 1'b1;
        if (valid_in) begin
          hold_d = beat_m << sh_r;
          if (!last_in) begin
            state_d = STREAM;
          end else if (kk > rr) begin
            ld      = 1'b1;
            ld_data = beat_m << sh_r;
            ld_keep = msb_mask(kk - rr);
            ld_last = 1'b1;
            state_d = DRAIN;
          end else begin
            state_d = IDLE;
          end
        end
      end
      STREAM: begin
        ready_in = out_free;
        if (valid_in && out_free) begin
          ld      = 1'b1;
          ld_data = hold | (beat_m >> sh_wr);
          ld_keep = '1;
          hold_d  = beat_m << sh_r;
          if (last_in) begin
            if (c > W_C) begin
              fcnt_d  = CW'(c - W_C);
              state_d = FLUSH;
            end else begin
              ld_keep = msb_mask(c);
              ld_last = 1'b1;
              state_d = DRAIN;
            end
          end
        end
      end
      FLUSH: begin
        if (out_free) begin
          ld      = 1'b1;
          ld_data = hold;
          ld_keep = msb_mask({1'b0, fcnt});
          ld_last = 1'b1;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_free)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      ready_in     = 1'b0;
      ready_remove = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      r         <= '0;
      hold      <= '0;
      fcnt      <= '0;
      valid_out <= 1'b0;
      data_out  <= '0;
      keep_out  <= '0;
      last_out  <= 1'b0;
    end else begin
      state <= state_d;
      r     <= r_d;
      hold  <= hold_d;
      fcnt  <= fcnt_d;
      if (ld) begin
        valid_out <= 1'b1;
        data_out  <= ld_data;
        keep_out  <= ld_keep;
        last_out  <= ld_last;
      end else if (ready_out) begin
        valid_out <= 1'b0;
      end
    end
  end

`ifdef AXIS_RM_HDR_ERR_EN
  logic drop, bad_keep;

  assign drop     = (state == FIRST) & valid_in & last_in & (kk <= rr);
  assign bad_keep = valid_in & ready_in & (keep_in != msb_mask(kk));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_short <= 1'b0;
    else
      err_short <= drop | bad_keep;
  end
`endif

endmodule

// File: tb/tb_axi_stream_remove_header.sv
// Directed bench for axi_stream_remove_header.
// Covers repacking, flush, pass-through, stalls, short drop and async reset.
module tb_axi_stream_remove_header;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic [31:0] data_in = '0;
  logic [3:0]  keep_in = '0;
  logic        last_in = 1'b0;
  logic        ready_in;
  logic        valid_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        last_out;
  logic        ready_out = 1'b1;
  logic        valid_remove = 1'b0;
  logic [1:0]  byte_remove_cnt = '0;
  logic        ready_remove;
`ifdef AXIS_RM_HDR_ERR_EN
  logic        err_short;
`endif

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic [36:0] q[$];
  int          cq[$];
  logic        stalled = 1'b0;
  logic [36:0] snap = '0;

  axi_stream_remove_header dut (
    .clk(clk),
    .rst(rst),
    .valid_in(valid_in),
    .data_in(data_in),
    .keep_in(keep_in),
    .last_in(last_in),
    .ready_in(ready_in),
    .valid_out(valid_out),
    .data_out(data_out),
    .keep_out(keep_out),
    .last_out(last_out),
    .ready_out(ready_out),
`ifdef AXIS_RM_HDR_ERR_EN
    .err_short(err_short),
`endif
    .valid_remove(valid_remove),
    .byte_remove_cnt(byte_remove_cnt),
    .ready_remove(ready_remove)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // output beats are logged where the handshake is settled for the next edge
  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_data", {last_out, keep_out, data_out}, snap);
        chk("stall_valid", valid_out, 1'b1);
      end
      stalled = valid_out & !ready_out;
      snap    = {last_out, keep_out, data_out};
      if (valid_out && ready_out) begin
        q.push_back({last_out, keep_out, data_out});
        cq.push_back(cyc);
      end
    end
  end

  task automatic cmd(input logic [1:0] r, output int w);
    w = 0;
    valid_remove    = 1'b1;
    byte_remove_cnt = r;
    @(negedge clk);
    while (!ready_remove && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("ready_remove_tmo", ready_remove, 1'b1);
    @(posedge clk);
    #1;
    valid_remove = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic [3:0] k,
                      input logic l, output int w);
    w = 0;
    valid_in = 1'b1;
    data_in  = d;
    keep_in  = k;
    last_in  = l;
    @(negedge clk);
    while (!ready_in && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("ready_in_tmo", ready_in, 1'b1);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    last_in  = 1'b0;
  endtask

  task automatic wait_q(input int n);
    int t;
    t = 0;
    while (q.size() < n && t < 100) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("beat_count", q.size(), n);
  endtask

  task automatic ex(input string tag, input int idx, input logic [31:0] d,
                    input logic [3:0] k, input logic l);
    logic [36:0] obs;
    obs = (idx < q.size()) ? q[idx] : 'x;
    chk(tag, obs, {l, k, d});
  endtask

  initial begin
    int w, ws;
    logic [3:0] pat;
    logic [31:0] d;
    pat = 4'b1001;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid_out", valid_out, 1'b0);
    chk("rst_data_out", data_out, 32'h0);
    chk("rst_keep_out", keep_out, 4'h0);
    chk("rst_last_out", last_out, 1'b0);
    chk("rst_ready_in", ready_in, 1'b0);
    chk("rst_ready_remove", ready_remove, 1'b0);
    rst = 1'b0;
    #1;
    chk("idle_ready_remove", ready_remove, 1'b1);
    chk("idle_ready_in", ready_in, 1'b0);

    // R=1, three beats, last full -> flush of three bytes
    q.delete(); cq.delete();
    cmd(2'd1, w);
    send(32'hAABBCCDD, 4'hF, 1'b0, w);
    send(32'h11223344, 4'hF, 1'b0, w);
    send(32'h55667788, 4'hF, 1'b1, w);
    wait_q(3);
    ex("t1_b0", 0, 32'hBBCCDD11, 4'hF, 1'b0);
    ex("t1_b1", 1, 32'h22334455, 4'hF, 1'b0);
    ex("t1_b2", 2, 32'h66778800, 4'hE, 1'b1);
    chk("t1_no_bubble", (cq.size() == 3) ? cq[2] - cq[0] : -1, 2);

    // same packet with ready_out toggling 1,0,0,1
    q.delete(); cq.delete();
    cmd(2'd1, w);
    ws = 0;
    fork
      begin
        send(32'hAABBCCDD, 4'hF, 1'b0, w);
        ws += w;
        send(32'h11223344, 4'hF, 1'b0, w);
        ws += w;
        send(32'h55667788, 4'hF, 1'b1, w);
        ws += w;
      end
      begin
        for (int i = 0; i < 12; i++) begin
          ready_out = pat[i % 4];
          @(posedge clk);
          #1;
        end
        ready_out = 1'b1;
      end
    join
    wait_q(3);
    ex("t4_b0", 0, 32'hBBCCDD11, 4'hF, 1'b0);
    ex("t4_b1", 1, 32'h22334455, 4'hF, 1'b0);
    ex("t4_b2", 2, 32'h66778800, 4'hE, 1'b1);
    chk("t4_backpressure", ws > 0, 1'b1);

    // R=3, last beat short -> single last beat
    q.delete(); cq.delete();
    cmd(2'd3, w);
    send(32'h01020304, 4'hF, 1'b0, w);
    send(32'hA1A2A3A4, 4'hC, 1'b1, w);
    wait_q(1);
    ex("t2a_b0", 0, 32'h04A1A200, 4'hE, 1'b1);
    chk("t2a_idle", ready_remove, 1'b1);

    // R=3, last beat full -> extra flush beat
    q.delete(); cq.delete();
    cmd(2'd3, w);
    send(32'h01020304, 4'hF, 1'b0, w);
    send(32'hA1A2A3A4, 4'hF, 1'b1, w);
    wait_q(2);
    ex("t2b_b0", 0, 32'h04A1A2A3, 4'hF, 1'b0);
    ex("t2b_b1", 1, 32'hA4000000, 4'h8, 1'b1);

    // R=0 pass-through, 16 full beats plus a 1-byte last
    q.delete(); cq.delete();
    cmd(2'd0, w);
    ws = 0;
    for (int i = 0; i < 16; i++) begin
      d = 32'hA0B0C0D0 + i * 32'h01010101;
      send(d, 4'hF, 1'b0, w);
      ws += w;
    end
    send(32'hC3123456, 4'h8, 1'b1, w);
    ws += w;
    wait_q(17);
    for (int i = 0; i < 16; i++) begin
      d = 32'hA0B0C0D0 + i * 32'h01010101;
      ex("t3_beat", i, d, 4'hF, 1'b0);
    end
    ex("t3_last", 16, 32'hC3000000, 4'h8, 1'b1);
    chk("t3_no_stall", ws, 0);
    chk("t3_no_bubble", (cq.size() == 17) ? cq[16] - cq[0] : -1, 16);

    // R=2, single short beat -> dropped
    q.delete(); cq.delete();
    cmd(2'd2, w);
    send(32'hDEADBEEF, 4'hC, 1'b1, w);
    chk("t5_idle", ready_remove, 1'b1);
`ifdef AXIS_RM_HDR_ERR_EN
    chk("t5_err_hi", err_short, 1'b1);
    @(posedge clk);
    #1;
    chk("t5_err_lo", err_short, 1'b0);
`endif
    cmd(2'd1, w);
    chk("t5_cmd_wait", w, 0);
    chk("t5_no_out", q.size(), 0);

    // async reset mid-stream, then a fresh packet
    send(32'hAABBCCDD, 4'hF, 1'b0, w);
    send(32'h11223344, 4'hF, 1'b0, w);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_valid_out", valid_out, 1'b0);
    chk("t6_data_out", data_out, 32'h0);
    chk("t6_keep_out", keep_out, 4'h0);
    chk("t6_last_out", last_out, 1'b0);
    chk("t6_ready_in", ready_in, 1'b0);
    chk("t6_ready_remove", ready_remove, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("t6_post_ready_remove", ready_remove, 1'b1);
    q.delete(); cq.delete();
    cmd(2'd1, w);
    send(32'h01234567, 4'hF, 1'b0, w);
    send(32'h89ABCDEF, 4'h8, 1'b1, w);
    wait_q(1);
    ex("t6_b0", 0, 32'h23456789, 4'hF, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, miscompares %0d", miscompares);
    $fatal(1, "watchdog");
  end

endmodule
